serial_transmitter: RTL

- Parallel-to-serial transmitter, the sending end of the team's 4-bit serial-in shift register link.
- Captures an NBITS_DATA word on a start/ready handshake and shifts it out LSB-first, framed by a start bit (0), an optional even-parity bit and a stop bit (1).
- Sits in top next to the receiver; LSB-first order means a right-shifting, MSB-insert receiver holds the original word after NBITS_DATA data bits.

---
 rtl/serial_pkg.sv | 7 +
 rtl/bit_period_timer.sv | 19 +
 rtl/serial_transmitter.sv | 89 ++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and line-level constants for the serial transmitter
package serial_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/bit_period_timer.sv
// bit_period_timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period
module bit_period_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk_2,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = cnt_q == CW'(CLKS_PER_BIT - 1);
    cnt_d = (clr || tick) ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge clk_2) begin
    cnt_q <= !reset ? '0 : cnt_d;
  end
endmodule

// File: rtl/serial_transmitter.sv
// serial_transmitter: LSB-first framed parallel-to-serial sender with optional even parity
module serial_transmitter
  import serial_pkg::*;
#(
  parameter int NBITS_DATA   = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 0
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic [NBITS_DATA-1:0] data_in_parallel,
  input  logic                  start,
  output logic                  ready,
  output logic                  busy,
  output logic                  serial_out,
  output logic                  done
);
  localparam int IW = $clog2(NBITS_DATA) + 1;
  tx_state_t state_q, state_d;
  logic [NBITS_DATA-1:0] shreg_q, shreg_d;
  logic [IW-1:0] idx_q, idx_d;
  logic parity_q, parity_d;
  logic serial_out_q, serial_out_d;
  logic ready_q, busy_q, done_q, done_d;
  logic tick;
  bit_period_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk_2 (clk_2),
    .reset (reset),
    .clr   (state_q == IDLE),
    .tick  (tick)
  );
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start && ready_q) begin
        state_d  = START;
        shreg_d  = data_in_parallel;
        idx_d    = '0;
        parity_d = ^data_in_parallel;
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        shreg_d = shreg_q >> 1;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(NBITS_DATA - 1)) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: if (tick) state_d = STOP;
      STOP: if (tick) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // line value is derived from the next state so it changes on the same edge as the state
    serial_out_d = state_d == START  ? START_BIT :
                   state_d == DATA   ? shreg_d[0] :
                   state_d == PARITY ? parity_d :
                   state_d == STOP   ? STOP_BIT : LINE_IDLE;
  end
  always_ff @(posedge clk_2) begin
    if (!reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      idx_q        <= '0;
      parity_q     <= 1'b0;
      serial_out_q <= LINE_IDLE;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      idx_q        <= idx_d;
      parity_q     <= parity_d;
      serial_out_q <= serial_out_d;
      ready_q      <= state_d == IDLE;
      busy_q       <= state_d != IDLE;
      done_q       <= done_d;
    end
  end
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign serial_out = serial_out_q;
  assign done       = done_q;
endmodule
